// File: rtl/lan_bus_master.sv
// Request/response word engine driving the pins of a W5300-style 16-bit LAN controller.
// Optional chip reset sequencer (RST_LOW/RST_WAIT states, LanRst pulse) is built when LAN_RST_GEN_EN is defined.
module lan_bus_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int MAX_WORDS    = 4,
  parameter int LEN_W        = 3,
  parameter int SETUP_CYC    = 5,
  parameter int STROBE_CYC   = 5,
  parameter int HOLD_CYC     = 5,
  parameter int RST_LOW_CYC  = 500,
  parameter int RST_WAIT_CYC = 1000000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic              ReqFifo,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [LEN_W-1:0]  ReqLen,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrValid,
  output logic              WrReady,
  output logic [DATA_W-1:0] RdData,
  output logic              RdValid,
  output logic              Done,
  output logic              Busy,
  output logic [ADDR_W-1:0] LanAddr,
  inout  wire  [DATA_W-1:0] LanData,
  output logic              LanCs,
  output logic              LanRd,
  output logic              LanWr,
  output logic              LanRst
);

  if (SETUP_CYC < 1 || STROBE_CYC < 1 || HOLD_CYC < 1 || RST_LOW_CYC < 1 || RST_WAIT_CYC < 1 ||
      MAX_WORDS < 1 || MAX_WORDS >= (1 << LEN_W)) begin : g_bad_params
    $error("lan_bus_master: illegal timing or length parameters");
  end

  localparam int TMAX  = (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                  : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W = $clog2(TMAX + 1);

`ifdef LAN_RST_GEN_EN
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RST_LOW, RST_WAIT} state_t;
  localparam state_t RESET_STATE = RST_LOW;
  localparam int RST_MAX   = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
  localparam int RST_CNT_W = $clog2(RST_MAX + 1);
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic                 lan_rst_q;
`else
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    left_q, left_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                write_q, write_d;
  logic                fifo_q, fifo_d;
  logic                taken_q, taken_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rd_data_d;
  logic                rd_valid_d, done_d, stall;
  logic                drive_q;

  // Drive/strobe flops reset asynchronously, so Rst releases the pins without waiting for Clk.
  assign LanData = drive_q ? wdata_q : {DATA_W{1'bz}};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    addr_d     = LanAddr;
    write_d    = write_q;
    fifo_d     = fifo_q;
    taken_d    = taken_q;
    wdata_d    = wdata_q;
    rd_data_d  = RdData;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    stall      = 1'b0;
`ifdef LAN_RST_GEN_EN
    rst_cnt_d  = rst_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (ReqValid) begin
          write_d = ReqWrite;
          fifo_d  = ReqFifo;
          addr_d  = ReqAddr;
          taken_d = 1'b0;
          cnt_d   = '0;
          if (ReqLen == '0)                    left_d = LEN_W'(1);
          else if (ReqLen > LEN_W'(MAX_WORDS)) left_d = LEN_W'(MAX_WORDS);
          else                                 left_d = ReqLen;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // A write cycle waiting for its data word does not count toward the setup time.
        stall = write_q && !taken_q && !WrValid;
        if (write_q && !taken_q && WrValid) begin
          taken_d = 1'b1;
          wdata_d = WrData;
        end
        if (!stall) begin
          if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
            cnt_d   = '0;
            state_d = STROBE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = HOLD;
          if (!write_q) begin
            rd_data_d  = LanData;
            rd_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d   = '0;
          taken_d = 1'b0;
          if (left_q > LEN_W'(1)) begin
            left_d  = left_q - LEN_W'(1);
            if (!fifo_q) addr_d = LanAddr + ADDR_W'(2);
            state_d = SETUP;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef LAN_RST_GEN_EN
      RST_LOW: begin
        if (rst_cnt_q == RST_CNT_W'(RST_LOW_CYC)) begin
          rst_cnt_d = RST_CNT_W'(1);
          state_d   = RST_WAIT;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        end
      end
      RST_WAIT: begin
        if (rst_cnt_q == RST_CNT_W'(RST_WAIT_CYC)) state_d = IDLE;
        else rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
      end
`endif
      default: state_d = RESET_STATE;
    endcase
  end

  // Pin and handshake outputs are registered from the next-state decode.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= RESET_STATE;
      cnt_q    <= '0;
      left_q   <= '0;
      write_q  <= 1'b0;
      fifo_q   <= 1'b0;
      taken_q  <= 1'b0;
      wdata_q  <= '0;
      drive_q  <= 1'b0;
      LanAddr  <= '0;
      LanCs    <= 1'b1;
      LanRd    <= 1'b1;
      LanWr    <= 1'b1;
      RdData   <= '0;
      RdValid  <= 1'b0;
      Done     <= 1'b0;
      WrReady  <= 1'b0;
      ReqReady <= 1'b0;
      Busy     <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      write_q  <= write_d;
      fifo_q   <= fifo_d;
      taken_q  <= taken_d;
      wdata_q  <= wdata_d;
      drive_q  <= taken_d;
      LanAddr  <= addr_d;
      LanCs    <= (state_d != STROBE);
      LanRd    <= !((state_d == STROBE) && !write_d);
      LanWr    <= !((state_d == STROBE) && write_d);
      RdData   <= rd_data_d;
      RdValid  <= rd_valid_d;
      Done     <= done_d;
      WrReady  <= (state_d == SETUP) && write_d && !taken_d;
      ReqReady <= (state_d == IDLE);
      Busy     <= (state_d != IDLE);
    end
  end

`ifdef LAN_RST_GEN_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rst_cnt_q <= '0;
      lan_rst_q <= 1'b0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      lan_rst_q <= (state_d != RST_LOW);
    end
  end
  assign LanRst = lan_rst_q;
`else
  assign LanRst = 1'b1;
`endif

endmodule

// File: tb/tb_lan_bus_master.sv
// Directed bench for lan_bus_master: write/read bursts, FIFO mode, SETUP stall, length clamp, mid-burst reset.
// Expected cycle numbers are hand-derived for SETUP=STROBE=HOLD=5 (P=15), MAX_WORDS=4.
module tb_lan_bus_master;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 3;

  logic              Clk, Rst;
  logic              ReqValid, ReqReady, ReqWrite, ReqFifo;
  logic [ADDR_W-1:0] ReqAddr;
  logic [LEN_W-1:0]  ReqLen;
  logic [DATA_W-1:0] WrData;
  logic              WrValid, WrReady;
  logic [DATA_W-1:0] RdData;
  logic              RdValid, Done, Busy;
  logic [ADDR_W-1:0] LanAddr;
  wire  [DATA_W-1:0] LanData;
  logic              LanCs, LanRd, LanWr, LanRst;

  // Chip-side driver: fills the bus whenever the master is expected to be high-Z.
  logic              chip_oe;
  logic [DATA_W-1:0] chip_val;
  assign LanData = chip_oe ? chip_val : {DATA_W{1'bz}};

  int checks, failures, cyc, wr_idx, k, ph, rv_cnt, done_cnt;
  logic [DATA_W-1:0] wr_words [4];
  logic [ADDR_W-1:0] exp_addr;
  logic              strobe, drv;

  lan_bus_master #(.RST_LOW_CYC(4), .RST_WAIT_CYC(10)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqFifo(ReqFifo),
    .ReqAddr(ReqAddr), .ReqLen(ReqLen),
    .WrData(WrData), .WrValid(WrValid), .WrReady(WrReady),
    .RdData(RdData), .RdValid(RdValid), .Done(Done), .Busy(Busy),
    .LanAddr(LanAddr), .LanData(LanData),
    .LanCs(LanCs), .LanRd(LanRd), .LanWr(LanWr), .LanRst(LanRst)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled 1 ns after the edge. Advances the write word on a handshake.
  task automatic step();
    logic hs;
    hs = WrValid && WrReady;
    @(posedge Clk);
    #1;
    cyc++;
    if (hs && wr_idx < 3) begin
      wr_idx++;
      WrData = wr_words[wr_idx];
    end
  endtask

  // Called with Rst high: checks reset values, releases Rst mid-cycle, checks the release sequence.
  task automatic reset_release_check();
    chip_oe  = 1'b1;
    chip_val = '0;
    #1;
    check("rst_cs",       32'(LanCs),    32'(1));
    check("rst_rd",       32'(LanRd),    32'(1));
    check("rst_wr",       32'(LanWr),    32'(1));
    check("rst_addr",     32'(LanAddr),  32'(0));
    check("rst_rddata",   32'(RdData),   32'(0));
    check("rst_rdvalid",  32'(RdValid),  32'(0));
    check("rst_done",     32'(Done),     32'(0));
    check("rst_wrready",  32'(WrReady),  32'(0));
    check("rst_reqready", 32'(ReqReady), 32'(0));
    check("rst_busy",     32'(Busy),     32'(1));
    check("rst_data_z",   32'(LanData),  32'(0));
`ifdef LAN_RST_GEN_EN
    check("rst_lanrst",   32'(LanRst),   32'(0));
`else
    check("rst_lanrst",   32'(LanRst),   32'(1));
`endif
    #2;
    Rst = 1'b0;
    cyc = 0;
`ifdef LAN_RST_GEN_EN
    for (int c = 1; c <= 15; c++) begin
      step();
      check("seq_lanrst",   32'(LanRst),   32'(c >= 5));
      check("seq_reqready", 32'(ReqReady), 32'(c >= 15));
      check("seq_done",     32'(Done),     32'(0));
    end
`else
    step();
    check("rel_reqready", 32'(ReqReady), 32'(1));
    check("rel_busy",     32'(Busy),     32'(0));
    check("rel_lanrst",   32'(LanRst),   32'(1));
    check("rel_done",     32'(Done),     32'(0));
`endif
  endtask

  // Waits (bounded) for ReqReady, presents the request in cycle 0, then scrambles request fields.
  task automatic start_req(input logic wr, input logic fifo, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len);
    int n;
    n = 0;
    while (!ReqReady && n < 100) begin
      step();
      n++;
    end
    check("req_ready_wait", 32'(ReqReady), 32'(1));
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqFifo  = fifo;
    ReqAddr  = addr;
    ReqLen   = len;
    wr_idx   = 0;
    WrData   = wr_words[0];
    cyc      = 0;
    step();
    ReqValid = 1'b0;
    ReqWrite = ~wr;
    ReqFifo  = ~fifo;
    ReqAddr  = '1;
    ReqLen   = 3'd6;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; wr_idx = 0;
    Rst = 1'b1;
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqFifo = 1'b0; ReqAddr = '0; ReqLen = '0;
    WrValid = 1'b0; WrData = '0;
    chip_oe = 1'b1; chip_val = '0;
    wr_words = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    step();
    step();
    reset_release_check();

    // Write burst of 3, incrementing address
    wr_words = '{16'hAABB, 16'hCCDD, 16'hEEFF, 16'h0000};
    WrValid  = 1'b1;
    start_req(1'b1, 1'b0, 10'h008, 3'd3);
    for (int c = 1; c <= 46; c++) begin
      if (c > 1) step();
      k   = (c - 1) / 15;
      ph  = (c - 1) % 15;
      drv = (c <= 45) && (ph >= 1);
      strobe   = (c <= 45) && (ph >= 5) && (ph <= 9);
      chip_oe  = !drv;
      chip_val = '0;
      exp_addr = (c <= 45) ? ADDR_W'(8 + 2 * k) : 10'h00C;
      #1;
      check("w_addr",     32'(LanAddr),  32'(exp_addr));
      check("w_lanwr",    32'(LanWr),    32'(!strobe));
      check("w_lancs",    32'(LanCs),    32'(!strobe));
      check("w_lanrd",    32'(LanRd),    32'(1));
      check("w_data",     32'(LanData),  drv ? 32'(wr_words[k]) : 32'(0));
      check("w_wrready",  32'(WrReady),  32'((c <= 45) && (ph == 0)));
      check("w_done",     32'(Done),     32'(c == 46));
      check("w_reqready", 32'(ReqReady), 32'(c == 46));
    end

    // Read burst of 2 in FIFO mode, accepted back-to-back in the IDLE cycle
    WrValid = 1'b0;
    start_req(1'b0, 1'b1, 10'h230, 3'd2);
    for (int c = 1; c <= 31; c++) begin
      if (c > 1) step();
      k   = (c - 1) / 15;
      ph  = (c - 1) % 15;
      strobe   = (c <= 30) && (ph >= 5) && (ph <= 9);
      chip_oe  = 1'b1;
      chip_val = strobe ? ((k == 0) ? 16'h1234 : 16'h5678) : 16'h0000;
      #1;
      check("r_addr",    32'(LanAddr), 32'(10'h230));
      check("r_lanrd",   32'(LanRd),   32'(!strobe));
      check("r_lancs",   32'(LanCs),   32'(!strobe));
      check("r_lanwr",   32'(LanWr),   32'(1));
      check("r_data_z",  32'(LanData), 32'(chip_val));
      check("r_rdvalid", 32'(RdValid), 32'((c == 11) || (c == 26)));
      check("r_wrready", 32'(WrReady), 32'(0));
      check("r_done",    32'(Done),    32'(c == 31));
      if (c == 11) check("r_rddata0", 32'(RdData), 32'(16'h1234));
      if (c == 26) check("r_rddata1", 32'(RdData), 32'(16'h5678));
    end
    check("r_rddata_hold", 32'(RdData), 32'(16'h5678));

    // Write burst of 2 with WrValid withheld for 10 cycles at the start of word 1
    wr_words = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};
    WrValid  = 1'b1;
    start_req(1'b1, 1'b0, 10'h100, 3'd2);
    for (int c = 1; c <= 41; c++) begin
      if (c > 1) step();
      WrValid  = !((c >= 16) && (c <= 25));
      drv      = ((c >= 2) && (c <= 15)) || ((c >= 27) && (c <= 40));
      strobe   = ((c >= 6) && (c <= 10)) || ((c >= 31) && (c <= 35));
      chip_oe  = !drv;
      chip_val = '0;
      #1;
      check("s_lancs",   32'(LanCs),   32'(!strobe));
      check("s_lanwr",   32'(LanWr),   32'(!strobe));
      check("s_data",    32'(LanData), drv ? ((c <= 15) ? 32'(16'h1111) : 32'(16'h2222)) : 32'(0));
      check("s_wrready", 32'(WrReady), 32'((c == 1) || ((c >= 16) && (c <= 26))));
      check("s_addr",    32'(LanAddr), (c <= 15) ? 32'(10'h100) : 32'(10'h102));
      check("s_done",    32'(Done),    32'(c == 41));
      check("s_busy",    32'(Busy),    32'(c != 41));
    end

    // ReqLen=0 is treated as a single word
    WrValid  = 1'b0;
    chip_oe  = 1'b1;
    chip_val = 16'hBEEF;
    start_req(1'b0, 1'b0, 10'h050, 3'd0);
    rv_cnt = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) step();
      if (RdValid) rv_cnt++;
      check("l0_done",     32'(Done),     32'(c == 16));
      check("l0_reqready", 32'(ReqReady), 32'(c == 16));
    end
    check("l0_rdvalid_cnt", 32'(rv_cnt), 32'(1));

    // ReqLen=7 is clamped to MAX_WORDS=4; address wraps modulo 2^ADDR_W
    start_req(1'b0, 1'b0, 10'h3FC, 3'd7);
    rv_cnt = 0;
    for (int c = 1; c <= 61; c++) begin
      if (c > 1) step();
      k  = (c - 1) / 15;
      ph = (c - 1) % 15;
      if (RdValid) rv_cnt++;
      exp_addr = 10'h3FC + ADDR_W'(2 * k);
      if (c <= 60 && ph == 5) check("l7_addr", 32'(LanAddr), 32'(exp_addr));
      check("l7_done", 32'(Done), 32'(c == 61));
    end
    check("l7_rdvalid_cnt", 32'(rv_cnt), 32'(4));
    check("l7_rddata",      32'(RdData), 32'(16'hBEEF));

    // Rst pulsed during the STROBE of word 1 of a write
    wr_words = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000};
    WrValid  = 1'b1;
    start_req(1'b1, 1'b0, 10'h040, 3'd2);
    done_cnt = 0;
    for (int c = 1; c <= 22; c++) begin
      if (c > 1) step();
      ph       = (c - 1) % 15;
      chip_oe  = !(ph >= 1);
      chip_val = '0;
      #1;
      if (Done) done_cnt++;
    end
    check("mr_pre_lanwr", 32'(LanWr),   32'(0));
    check("mr_pre_lancs", 32'(LanCs),   32'(0));
    check("mr_pre_data",  32'(LanData), 32'(16'h5A5A));
    Rst      = 1'b1;
    chip_oe  = 1'b1;
    chip_val = '0;
    #1;
    check("mr_lancs",   32'(LanCs),   32'(1));
    check("mr_lanwr",   32'(LanWr),   32'(1));
    check("mr_data_z",  32'(LanData), 32'(0));
    check("mr_rdvalid", 32'(RdValid), 32'(0));
    for (int i = 0; i < 2; i++) begin
      step();
      if (Done) done_cnt++;
    end
    check("mr_no_done", 32'(done_cnt), 32'(0));
    reset_release_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
